// File: rtl/serv_dbg_ctrl.sv
// Host-side debug controller for SERV: halt/step/reset sequencing plus a trace FIFO of rebuilt 32-bit RF writes.
// Optional macro SERV_DBG_TS_EN adds a free-running timestamp stored with every trace entry.
module serv_dbg_ctrl #(
  parameter int RF_WIDTH   = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int RST_CYCLES = 4,
  parameter int TS_W       = 16
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [1:0]          i_cmd,
  output logic                o_dbg_halt,
  output logic                o_dbg_reset,
  input  logic                i_dbg_process,
  input  logic                i_dbg_step,
  input  logic [5:0]          i_rf_waddr,
  input  logic                i_rf_w1wren,
  input  logic                i_rf_we,
  input  logic [RF_WIDTH-1:0] i_rf_wdata,
  output logic                o_halted,
  output logic                o_trace_valid,
  input  logic                i_trace_ready,
  output logic [5:0]          o_trace_reg,
  output logic [31:0]         o_trace_data,
  output logic [TS_W-1:0]     o_trace_ts,
  output logic                o_trace_ovf,
  input  logic                i_trace_clr
);

  localparam logic [1:0] CMD_HALT   = 2'd0;
  localparam logic [1:0] CMD_RESUME = 2'd1;
  localparam logic [1:0] CMD_STEP   = 2'd2;
  localparam logic [1:0] CMD_RESET  = 2'd3;

  localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam int              AW      = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_RUN,
    S_HALT_WAIT,
    S_HALTED,
    S_STEP_RUN,
    S_RST
  } state_t;

  state_t          state, state_nxt;
  logic [RC_W-1:0] rst_cnt;
  logic            rst_from_halted;

  // Outside RST the origin flag tracks HALTED, so it holds the entry state once RST begins.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state           <= S_RUN;
      rst_cnt         <= '0;
      rst_from_halted <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_RST) begin
        rst_cnt <= rst_cnt + RC_W'(1);
      end else begin
        rst_cnt         <= '0;
        rst_from_halted <= (state == S_HALTED);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    o_cmd_ready = 1'b0;
    o_dbg_halt  = 1'b0;
    o_dbg_reset = 1'b0;
    o_halted    = 1'b0;
    case (state)
      S_RUN: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          case (i_cmd)
            CMD_HALT:  state_nxt = S_HALT_WAIT;
            CMD_STEP:  state_nxt = S_STEP_RUN;
            CMD_RESET: state_nxt = S_RST;
            default:   state_nxt = S_RUN;
          endcase
        end
      end
      S_HALT_WAIT: begin
        o_dbg_halt = 1'b1;
        if (i_dbg_process) state_nxt = S_HALTED;
      end
      S_HALTED: begin
        o_dbg_halt  = 1'b1;
        o_halted    = 1'b1;
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          case (i_cmd)
            CMD_RESUME: state_nxt = S_RUN;
            CMD_STEP:   state_nxt = S_STEP_RUN;
            CMD_RESET:  state_nxt = S_RST;
            default:    state_nxt = S_HALTED;
          endcase
        end
      end
      S_STEP_RUN: begin
        if (i_dbg_step) state_nxt = S_HALT_WAIT;
      end
      S_RST: begin
        o_dbg_reset = 1'b1;
        if (rst_cnt == RC_LAST) state_nxt = rst_from_halted ? S_HALT_WAIT : S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  logic                  beat, same_reg, push;
  logic [1:0]            asm_cnt;
  logic [3*RF_WIDTH-1:0] asm_part;
  logic [5:0]            asm_idx;

  assign beat     = i_rf_we & i_rf_w1wren;
  assign same_reg = (asm_cnt != 2'd0) && (i_rf_waddr == asm_idx);
  assign push     = beat & same_reg & (asm_cnt == 2'd3) & (asm_idx != 6'd0)
                    & (state != S_RST) & ~i_trace_clr;

  // A beat to a different register restarts assembly with that beat as byte 0.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      asm_cnt  <= 2'd0;
      asm_part <= '0;
      asm_idx  <= 6'd0;
    end else if (state == S_RST || i_trace_clr) begin
      asm_cnt  <= 2'd0;
      asm_part <= '0;
    end else if (beat) begin
      if (!same_reg) begin
        asm_idx  <= i_rf_waddr;
        asm_part <= {{(2*RF_WIDTH){1'b0}}, i_rf_wdata};
        asm_cnt  <= 2'd1;
      end else begin
        case (asm_cnt)
          2'd1:    asm_part[2*RF_WIDTH-1:RF_WIDTH]   <= i_rf_wdata;
          2'd2:    asm_part[3*RF_WIDTH-1:2*RF_WIDTH] <= i_rf_wdata;
          default: asm_part <= asm_part;
        endcase
        asm_cnt <= asm_cnt + 2'd1;
      end
    end
  end

  logic [AW:0]  wptr, rptr;
  logic         empty, full, pop, wr;
  logic [5:0]   mem_reg  [FIFO_DEPTH];
  logic [31:0]  mem_data [FIFO_DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = i_trace_ready & ~empty;
  assign wr    = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (i_rst || i_trace_clr) begin
      wptr        <= '0;
      rptr        <= '0;
      o_trace_ovf <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
      if (push && full && !pop) o_trace_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_reg[wptr[AW-1:0]]  <= asm_idx;
      mem_data[wptr[AW-1:0]] <= {i_rf_wdata, asm_part};
    end
  end

  assign o_trace_valid = ~empty;
  assign o_trace_reg   = mem_reg[rptr[AW-1:0]];
  assign o_trace_data  = mem_data[rptr[AW-1:0]];

`ifdef SERV_DBG_TS_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] mem_ts [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (i_rst) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + TS_W'(1);
  end

  // The stamp is the counter value on the byte-3 beat edge.
  always_ff @(posedge clk) begin
    if (wr) mem_ts[wptr[AW-1:0]] <= ts_cnt;
  end

  assign o_trace_ts = mem_ts[rptr[AW-1:0]];
`else
  assign o_trace_ts = '0;
`endif

endmodule

// File: tb/tb_serv_dbg_ctrl.sv
// Self-checking bench for serv_dbg_ctrl: directed command/write sequences checked against a queue model of the trace FIFO.
module tb_serv_dbg_ctrl;

  localparam int FIFO_DEPTH = 16;
  localparam int TS_W       = 16;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_cmd_valid = 1'b0;
  logic            o_cmd_ready;
  logic [1:0]      i_cmd = 2'd0;
  logic            o_dbg_halt, o_dbg_reset;
  logic            i_dbg_process = 1'b0;
  logic            i_dbg_step = 1'b0;
  logic [5:0]      i_rf_waddr = 6'd0;
  logic            i_rf_w1wren = 1'b0;
  logic            i_rf_we = 1'b0;
  logic [7:0]      i_rf_wdata = 8'd0;
  logic            o_halted, o_trace_valid;
  logic            i_trace_ready = 1'b0;
  logic [5:0]      o_trace_reg;
  logic [31:0]     o_trace_data;
  logic [TS_W-1:0] o_trace_ts;
  logic            o_trace_ovf;
  logic            i_trace_clr = 1'b0;

  always #5 clk = ~clk;

  serv_dbg_ctrl #(
    .RF_WIDTH(8), .FIFO_DEPTH(FIFO_DEPTH), .RST_CYCLES(4), .TS_W(TS_W)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd(i_cmd), .o_dbg_halt(o_dbg_halt), .o_dbg_reset(o_dbg_reset),
    .i_dbg_process(i_dbg_process), .i_dbg_step(i_dbg_step), .i_rf_waddr(i_rf_waddr),
    .i_rf_w1wren(i_rf_w1wren), .i_rf_we(i_rf_we), .i_rf_wdata(i_rf_wdata),
    .o_halted(o_halted), .o_trace_valid(o_trace_valid), .i_trace_ready(i_trace_ready),
    .o_trace_reg(o_trace_reg), .o_trace_data(o_trace_data), .o_trace_ts(o_trace_ts),
    .o_trace_ovf(o_trace_ovf), .i_trace_clr(i_trace_clr)
  );

  int          checkCount = 0;
  int          passCount  = 0;
  logic [37:0] expQ[$];
  logic        mOvf = 1'b0;
  bit          cmpEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  task automatic checkFsm(input string tag, input logic halt, input logic rst, input logic hlt, input logic rdy);
    checkOutput({tag, ".dbg_halt"},  32'(o_dbg_halt),  32'(halt));
    checkOutput({tag, ".dbg_reset"}, 32'(o_dbg_reset), 32'(rst));
    checkOutput({tag, ".halted"},    32'(o_halted),    32'(hlt));
    checkOutput({tag, ".cmd_ready"}, 32'(o_cmd_ready), 32'(rdy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] cmd);
    i_cmd_valid = 1'b1;
    i_cmd       = cmd;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic setBeat(input logic [5:0] idx, input logic [7:0] b);
    i_rf_we     = 1'b1;
    i_rf_w1wren = 1'b1;
    i_rf_waddr  = idx;
    i_rf_wdata  = b;
  endtask

  task automatic beat(input logic [5:0] idx, input logic [7:0] b);
    setBeat(idx, b);
    tick();
  endtask

  task automatic idle();
    i_rf_we     = 1'b0;
    i_rf_w1wren = 1'b0;
  endtask

  // Model: a completed non-x0 write is one FIFO entry; a full FIFO drops it unless a pop frees a slot.
  task automatic modelWrite(input logic [5:0] idx, input logic [31:0] value);
    if (idx != 6'd0) begin
      if (expQ.size() == FIFO_DEPTH) mOvf = 1'b1;
      else expQ.push_back({idx, value});
    end
  endtask

  task automatic writeReg(input logic [5:0] idx, input logic [31:0] value, input bit popLast);
    beat(idx, value[7:0]);
    beat(idx, value[15:8]);
    beat(idx, value[23:16]);
    setBeat(idx, value[31:24]);
    i_trace_ready = popLast;
    tick();
    i_trace_ready = 1'b0;
    idle();
    if (popLast && expQ.size() != 0) void'(expQ.pop_front());
    modelWrite(idx, value);
    tick();
  endtask

  task automatic popOne();
    i_trace_ready = 1'b1;
    tick();
    i_trace_ready = 1'b0;
    if (expQ.size() != 0) void'(expQ.pop_front());
  endtask

  task automatic clearTrace();
    i_trace_clr = 1'b1;
    tick();
    i_trace_clr = 1'b0;
    expQ.delete();
    mOvf = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("cmp.trace_valid", 32'(o_trace_valid), 32'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        checkOutput("cmp.trace_reg",  32'(o_trace_reg), 32'(expQ[0][37:32]));
        checkOutput("cmp.trace_data", o_trace_data,     expQ[0][31:0]);
      end
      checkOutput("cmp.trace_ovf", 32'(o_trace_ovf), 32'(mOvf));
`ifndef SERV_DBG_TS_EN
      checkOutput("cmp.trace_ts", 32'(o_trace_ts), 32'd0);
`endif
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tick();
    tick();
    checkFsm("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset.trace_valid", 32'(o_trace_valid), 32'd0);
    checkOutput("reset.trace_ovf",   32'(o_trace_ovf),   32'd0);
    i_rst = 1'b0;
    cmpEn = 1'b1;
    tick();

    applyStimulus(2'd1);
    checkFsm("resume_in_run", 1'b0, 1'b0, 1'b0, 1'b1);

    writeReg(6'd5, 32'h12345678, 1'b0);
    checkOutput("w5.reg",  32'(o_trace_reg), 32'd5);
    checkOutput("w5.data", o_trace_data,     32'h12345678);
    popOne();
    writeReg(6'd0, 32'h12345678, 1'b0);
    checkOutput("w0.valid", 32'(o_trace_valid), 32'd0);

    beat(6'd9, 8'h01);
    beat(6'd9, 8'h02);
    writeReg(6'd10, 32'hCAFEF00D, 1'b0);
    checkOutput("idx_change.reg",  32'(o_trace_reg), 32'd10);
    checkOutput("idx_change.data", o_trace_data,     32'hCAFEF00D);
    popOne();

    beat(6'd11, 8'hEF);
    beat(6'd11, 8'hBE);
    setBeat(6'd11, 8'hFF);
    i_rf_w1wren = 1'b0;
    tick();
    beat(6'd11, 8'hAD);
    beat(6'd11, 8'hDE);
    idle();
    modelWrite(6'd11, 32'hDEADBEEF);
    tick();
    checkOutput("we_only.data", o_trace_data, 32'hDEADBEEF);
    popOne();
    popOne();
    checkOutput("pop_empty.valid", 32'(o_trace_valid), 32'd0);

    for (int i = 0; i < FIFO_DEPTH + 1; i++) writeReg(6'(i + 1), 32'hA5000000 + i, 1'b0);
    checkOutput("ovf.set",      32'(o_trace_ovf), 32'd1);
    checkOutput("ovf.head_reg", 32'(o_trace_reg), 32'd1);
    writeReg(6'd20, 32'h0BADF00D, 1'b1);
    checkOutput("full_pop.head_reg", 32'(o_trace_reg), 32'd2);
    for (int i = 0; i < 3; i++) popOne();
    clearTrace();
    checkOutput("clr.valid", 32'(o_trace_valid), 32'd0);
    checkOutput("clr.ovf",   32'(o_trace_ovf),   32'd0);

    applyStimulus(2'd0);
    checkFsm("halt_wait0", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkFsm("halt_wait1", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkFsm("halt_wait2", 1'b1, 1'b0, 1'b0, 1'b0);
    i_dbg_process = 1'b1;
    tick();
    checkFsm("halted", 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(2'd0);
    checkFsm("halt_in_halted", 1'b1, 1'b0, 1'b1, 1'b1);

    applyStimulus(2'd2);
    i_dbg_process = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("step_run.dbg_halt", 32'(o_dbg_halt), 32'd0);
      checkOutput("step_run.halted",   32'(o_halted),   32'd0);
      tick();
    end
    i_dbg_step = 1'b1;
    tick();
    i_dbg_step = 1'b0;
    checkFsm("step_halt_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    i_dbg_process = 1'b1;
    tick();
    checkFsm("step_halted", 1'b1, 1'b0, 1'b1, 1'b1);

    beat(6'd7, 8'h11);
    beat(6'd7, 8'h22);
    setBeat(6'd7, 8'h33);
    applyStimulus(2'd3);
    idle();
    i_dbg_process = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkFsm("rst_from_halted", 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    checkFsm("rst_to_halt_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    i_dbg_process = 1'b1;
    tick();
    checkFsm("rst_halted", 1'b1, 1'b0, 1'b1, 1'b1);
    writeReg(6'd7, 32'hAABBCCDD, 1'b0);
    checkOutput("after_rst.data", o_trace_data, 32'hAABBCCDD);
    popOne();

    applyStimulus(2'd1);
    i_dbg_process = 1'b0;
    checkFsm("resume", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'd3);
    for (int i = 0; i < 4; i++) begin
      checkFsm("rst_from_run", 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    checkFsm("rst_to_run", 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SERV_DBG_TS_EN
    begin
      logic [TS_W-1:0] tsA;
      writeReg(6'd3, 32'h00000003, 1'b0);
      tick();
      tick();
      writeReg(6'd4, 32'h00000004, 1'b0);
      tsA = o_trace_ts;
      popOne();
      checkOutput("ts_delta", 32'(TS_W'(o_trace_ts - tsA)), 32'd7);
      popOne();
    end
`endif

    tick();
    cmpEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
